// File: rtl/pipelined_cla_addsub_if.sv
// Handshake and data bundle for pipelined_cla_addsub: the input operation channel and the result channel.
// The master side drives operations and consumes results; the slave side is the adder pipeline.
interface pipelined_cla_addsub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic             out_zero;

    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
    );
endinterface

// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor: one BLOCK-bit lookahead group per stage, group carry registered
// between stages, single global stall driven by the output handshake. The bus interface must use the same WIDTH.
module pipelined_cla_addsub #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input logic                   clk,
    input logic                   rst_n,
    pipelined_cla_addsub_if.slave bus
);
    localparam int NS = WIDTH / BLOCK;

    if (BLOCK < 1 || BLOCK > 8 || (WIDTH % BLOCK) != 0) begin : g_param_check
        $error("pipelined_cla_addsub: WIDTH must be a multiple of BLOCK and BLOCK must be 1..8");
    end

    // Flattened sum-of-products carries: every c[i] comes straight from g, p and the group carry-in.
    function automatic logic [BLOCK:0] cla_carries(input logic [BLOCK-1:0] p,
                                                   input logic [BLOCK-1:0] g,
                                                   input logic             c0);
        logic [BLOCK:0] c;
        logic           prod;
        c    = '0;
        c[0] = c0;
        for (int i = 0; i < BLOCK; i++) begin
            prod = c0;
            for (int k = 0; k <= i; k++) prod = prod & p[k];
            c[i+1] = prod;
            for (int j = 0; j <= i; j++) begin
                prod = g[j];
                for (int k = j + 1; k <= i; k++) prod = prod & p[k];
                c[i+1] = c[i+1] | prod;
            end
        end
        return c;
    endfunction

    // Rank k holds an op about to resolve group k: word_p mixes produced sum bits (below the group)
    // with untouched A bits (the group and above); b_p is the raw B skew register.
    logic [WIDTH-1:0] word_p [NS];
    logic [WIDTH-1:0] b_p    [NS];
    logic             sub_p  [NS];
    logic             c_p    [NS];
    logic             vld_p  [NS];

    logic [WIDTH-1:0] word_nx [NS];
    logic             c_nx    [NS];
    logic [1:0]       last_top;

    logic             adv;
    logic             out_vld;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             zero_q;

    assign adv          = ~out_vld | bus.out_ready;
    assign bus.in_ready = adv;
    assign bus.out_valid = out_vld;
    assign bus.out_sum   = sum_q;
    assign bus.out_cout  = cout_q;
    assign bus.out_ovf   = ovf_q;
    assign bus.out_zero  = zero_q;

    always_comb begin : stage_logic
        logic [BLOCK-1:0] a_s;
        logic [BLOCK-1:0] b_s;
        logic [BLOCK-1:0] p;
        logic [BLOCK-1:0] g;
        logic [BLOCK:0]   cc;
        a_s      = '0;
        b_s      = '0;
        p        = '0;
        g        = '0;
        cc       = '0;
        last_top = '0;
        for (int k = 0; k < NS; k++) begin
            a_s = word_p[k][k*BLOCK +: BLOCK];
            b_s = b_p[k][k*BLOCK +: BLOCK] ^ {BLOCK{sub_p[k]}};
            p   = a_s ^ b_s;
            g   = a_s & b_s;
            cc  = cla_carries(p, g, c_p[k]);
            word_nx[k]                    = word_p[k];
            word_nx[k][k*BLOCK +: BLOCK]  = p ^ cc[BLOCK-1:0];
            c_nx[k]                       = cc[BLOCK];
            if (k == NS - 1) last_top = cc[BLOCK -: 2];
        end
    end

    // Control: valid bits and the output register bank (cleared immediately on reset)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NS; r++) vld_p[r] <= 1'b0;
            out_vld <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else if (adv) begin
            vld_p[0] <= bus.in_valid;
            for (int r = 1; r < NS; r++) vld_p[r] <= vld_p[r-1];
            out_vld <= vld_p[NS-1];
            if (vld_p[NS-1]) begin
                sum_q  <= word_nx[NS-1];
                cout_q <= c_nx[NS-1];
                ovf_q  <= last_top[1] ^ last_top[0];
                zero_q <= (word_nx[NS-1] == '0);
            end
        end
    end

    // Datapath ranks: capture into rank 0, then each rank hands its resolved group to the next
    always_ff @(posedge clk) begin
        if (adv) begin
            if (bus.in_valid) begin
                word_p[0] <= bus.in_a;
                b_p[0]    <= bus.in_b;
                sub_p[0]  <= bus.in_sub;
                c_p[0]    <= bus.in_sub | bus.in_cin;
            end
            for (int r = 1; r < NS; r++) begin
                word_p[r] <= word_nx[r-1];
                b_p[r]    <= b_p[r-1];
                sub_p[r]  <= sub_p[r-1];
                c_p[r]    <= c_nx[r-1];
            end
        end
    end
endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Directed bench for pipelined_cla_addsub: 16/4 table vectors, back-to-back streams on 16/4, 8/2 and 8/8,
// output stall with simultaneous retire/accept, and asynchronous reset with ops in flight.
module tb_pipelined_cla_addsub;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    pipelined_cla_addsub_if #(.WIDTH(16)) b16 ();
    pipelined_cla_addsub_if #(.WIDTH(8))  b8a ();
    pipelined_cla_addsub_if #(.WIDTH(8))  b8b ();

    pipelined_cla_addsub #(.WIDTH(16), .BLOCK(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));
    pipelined_cla_addsub #(.WIDTH(8),  .BLOCK(2)) dut8a (.clk(clk), .rst_n(rst_n), .bus(b8a));
    pipelined_cla_addsub #(.WIDTH(8),  .BLOCK(8)) dut8b (.clk(clk), .rst_n(rst_n), .bus(b8b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
        logic acc;
        int   n;
        b16.in_valid = 1'b1;
        b16.in_a     = a;
        b16.in_b     = b;
        b16.in_cin   = cin;
        b16.in_sub   = sub;
        n = 0;
        do begin
            acc = b16.in_ready;
            step();
            n++;
        end while (!acc && n < 20);
        b16.in_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready stayed %0b", acc);
        end
    endtask

    task automatic wait_out16(output int lat);
        lat = 0;
        while (!b16.out_valid && lat < 20) begin
            step();
            lat++;
        end
    endtask

    initial begin
        int lat;
        int got;
        int stale;
        checks = 0;
        errors = 0;

        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{16'hABCD, 16'hABCD, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000F, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
        vecs[9] = '{16'h00F0, 16'h000F, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0};

        b16.in_valid = 1'b0; b16.in_a = '0; b16.in_b = '0; b16.in_cin = 1'b0; b16.in_sub = 1'b0; b16.out_ready = 1'b1;
        b8a.in_valid = 1'b0; b8a.in_a = '0; b8a.in_b = '0; b8a.in_cin = 1'b0; b8a.in_sub = 1'b0; b8a.out_ready = 1'b1;
        b8b.in_valid = 1'b0; b8b.in_a = '0; b8b.in_b = '0; b8b.in_cin = 1'b0; b8b.in_sub = 1'b0; b8b.out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", {31'd0, b16.out_valid}, 32'd0);
        chk("reset_in_ready", {31'd0, b16.in_ready}, 32'd1);
        chk("reset_out_sum", {16'd0, b16.out_sum}, 32'd0);
        chk("reset_flags", {29'd0, b16.out_cout, b16.out_ovf, b16.out_zero}, 32'd0);
        rst_n = 1'b1;
        step();

        // Table: one op at a time, latency and all result fields
        for (int i = 0; i < 10; i++) begin
            send16(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
            wait_out16(lat);
            chk($sformatf("vec%0d_latency", i), lat, 32'd4);
            chk($sformatf("vec%0d_sum", i), {16'd0, b16.out_sum}, {16'd0, vecs[i].sum});
            chk($sformatf("vec%0d_cout", i), {31'd0, b16.out_cout}, {31'd0, vecs[i].cout});
            chk($sformatf("vec%0d_ovf", i), {31'd0, b16.out_ovf}, {31'd0, vecs[i].ovf});
            chk($sformatf("vec%0d_zero", i), {31'd0, b16.out_zero}, {31'd0, vecs[i].zero});
            step();
        end
        repeat (2) step();

        // Back-to-back: a=i, b=3*i on all three widths; op i accepted at edge i+1, result after edge i+1+NS
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    b16.in_valid = 1'b1; b16.in_a = 16'(i); b16.in_b = 16'(3 * i); b16.in_cin = 1'b0; b16.in_sub = 1'b0;
                    b8a.in_valid = 1'b1; b8a.in_a = 8'(i);  b8a.in_b = 8'(3 * i);  b8a.in_cin = 1'b0; b8a.in_sub = 1'b0;
                    b8b.in_valid = 1'b1; b8b.in_a = 8'(i);  b8b.in_b = 8'(3 * i);  b8b.in_cin = 1'b0; b8b.in_sub = 1'b0;
                    step();
                end
                b16.in_valid = 1'b0;
                b8a.in_valid = 1'b0;
                b8b.in_valid = 1'b0;
            end
            begin
                int n16;
                n16 = 0;
                for (int k = 1; k <= 20; k++) begin
                    step();
                    if (b16.out_valid) begin
                        chk($sformatf("b2b16_sum%0d", n16), {16'd0, b16.out_sum}, 32'(4 * n16));
                        chk($sformatf("b2b16_cyc%0d", n16), k, 32'(n16 + 1 + 4));
                        n16++;
                    end
                end
                chk("b2b16_count", n16, 32'd8);
            end
            begin
                int n8a;
                n8a = 0;
                for (int k = 1; k <= 20; k++) begin
                    step();
                    if (b8a.out_valid) begin
                        chk($sformatf("b2b8x2_sum%0d", n8a), {24'd0, b8a.out_sum}, 32'(4 * n8a));
                        chk($sformatf("b2b8x2_cyc%0d", n8a), k, 32'(n8a + 1 + 4));
                        n8a++;
                    end
                end
                chk("b2b8x2_count", n8a, 32'd8);
            end
            begin
                int n8b;
                n8b = 0;
                for (int k = 1; k <= 20; k++) begin
                    step();
                    if (b8b.out_valid) begin
                        chk($sformatf("b2b8x8_sum%0d", n8b), {24'd0, b8b.out_sum}, 32'(4 * n8b));
                        chk($sformatf("b2b8x8_cyc%0d", n8b), k, 32'(n8b + 1 + 1));
                        n8b++;
                    end
                end
                chk("b2b8x8_count", n8b, 32'd8);
            end
        join

        // Stall: fill all five slots with out_ready low, hold 3 cycles, then retire and accept together
        b16.out_ready = 1'b0;
        step();
        for (int j = 0; j < 5; j++) send16(16'(100 + j), 16'(j), 1'b0, 1'b0);
        chk("stall_in_ready", {31'd0, b16.in_ready}, 32'd0);
        chk("stall_out_valid", {31'd0, b16.out_valid}, 32'd1);
        chk("stall_sum", {16'd0, b16.out_sum}, 32'd100);
        for (int h = 0; h < 3; h++) begin
            step();
            chk($sformatf("hold%0d_sum", h), {16'd0, b16.out_sum}, 32'd100);
            chk($sformatf("hold%0d_valid", h), {31'd0, b16.out_valid}, 32'd1);
            chk($sformatf("hold%0d_in_ready", h), {31'd0, b16.in_ready}, 32'd0);
        end
        b16.out_ready = 1'b1;
        b16.in_valid  = 1'b1;
        b16.in_a      = 16'd105;
        b16.in_b      = 16'd5;
        #1;
        chk("release_in_ready", {31'd0, b16.in_ready}, 32'd1);
        got = 0;
        for (int cyc = 0; cyc < 20 && got < 6; cyc++) begin
            if (b16.out_valid) begin
                chk($sformatf("release_sum%0d", got), {16'd0, b16.out_sum}, 32'(100 + 2 * got));
                got++;
            end
            step();
            if (cyc == 0) b16.in_valid = 1'b0;
        end
        chk("release_count", got, 32'd6);
        stale = 0;
        repeat (4) begin
            if (b16.out_valid) stale++;
            step();
        end
        chk("release_no_dup", stale, 32'd0);

        // Reset with three ops in flight
        for (int j = 0; j < 3; j++) send16(16'h0100, 16'(j + 1), 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, b16.out_valid}, 32'd0);
        chk("rst_out_sum", {16'd0, b16.out_sum}, 32'd0);
        step();
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", {31'd0, b16.in_ready}, 32'd1);
        stale = 0;
        repeat (8) begin
            step();
            if (b16.out_valid) stale++;
        end
        chk("rst_no_stale", stale, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
